// File: rtl/arbiter_rr_if.sv
// Bundle of the signals between the round-robin arbiter and its input/output FIFOs.
// master is the arbiter side; slave is the FIFO side that drives the status flags.
interface arbiter_rr_if #(
  parameter int FIFO_UNITS = 4,
  parameter int DEST_W     = 2
);
  logic [FIFO_UNITS-1:0] fifo_empty;
  logic [DEST_W-1:0]     head_dest0;
  logic [DEST_W-1:0]     head_dest1;
  logic [DEST_W-1:0]     head_dest2;
  logic [DEST_W-1:0]     head_dest3;
  logic [FIFO_UNITS-1:0] fifo_almost_full;
  logic [FIFO_UNITS-1:0] arb_pop;
  logic [FIFO_UNITS-1:0] arb_push;
  logic [1:0]            arb_state;
  logic                  idle;

  modport master (
    input  fifo_empty, head_dest0, head_dest1, head_dest2, head_dest3, fifo_almost_full,
    output arb_pop, arb_push, arb_state, idle
  );

  modport slave (
    output fifo_empty, head_dest0, head_dest1, head_dest2, head_dest3, fifo_almost_full,
    input  arb_pop, arb_push, arb_state, idle
  );
endinterface

// File: rtl/arbiter_rr.sv
// Round-robin arbiter moving words from four input FIFOs to four output FIFOs.
// A grant pops the input FIFO one cycle later and pushes the captured destination one cycle after that.
module arbiter_rr #(
  parameter int FIFO_UNITS = 4,
  parameter int DEST_W     = 2
) (
  input  logic         clk,
  input  logic         reset_L,
  arbiter_rr_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_STALL = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [1:0]            ptr_q;
  logic [DEST_W-1:0]     dest_q;
  logic [FIFO_UNITS-1:0] pop_q;
  logic [FIFO_UNITS-1:0] push_q;

  logic [DEST_W-1:0]     head_dest [FIFO_UNITS];
  logic [FIFO_UNITS-1:0] pending;
  logic [FIFO_UNITS-1:0] eligible;
  logic                  any_pending;
  logic                  any_eligible;
  logic                  grant;
  logic [1:0]            grant_idx;
  logic                  found;
  logic [1:0]            cand;

  assign head_dest[0] = bus.head_dest0;
  assign head_dest[1] = bus.head_dest1;
  assign head_dest[2] = bus.head_dest2;
  assign head_dest[3] = bus.head_dest3;

  assign pending     = ~bus.fifo_empty;
  assign any_pending = |pending;

  // A FIFO popped this cycle still looks non-empty (its flag lags), so it is masked here.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < FIFO_UNITS; i++) begin
      eligible[i] = pending[i] & ~bus.fifo_almost_full[head_dest[i]] & ~pop_q[i];
    end
  end

  assign any_eligible = |eligible;

  // Search ptr, ptr+1, ptr+2, ptr+3 (mod 4); first eligible candidate wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < FIFO_UNITS; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && eligible[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_pending) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (!any_pending)       state_d = ST_IDLE;
        else if (!any_eligible) state_d = ST_STALL;
      end
      ST_STALL: begin
        if (!any_pending)      state_d = ST_IDLE;
        else if (any_eligible) state_d = ST_SERVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grants are evaluated in the cycle the FSM decides to be in SERVE next.
  assign grant = found && (state_d == ST_SERVE);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'b00;
      dest_q  <= '0;
      pop_q   <= '0;
      push_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        pop_q  <= FIFO_UNITS'(1) << grant_idx;
        ptr_q  <= grant_idx + 2'd1;
        dest_q <= head_dest[grant_idx];
      end else begin
        pop_q  <= '0;
      end
      // dest_q here is still the value captured with the pop now completing.
      if (|pop_q) push_q <= FIFO_UNITS'(1) << dest_q;
      else        push_q <= '0;
    end
  end

  assign bus.arb_pop   = pop_q;
  assign bus.arb_push  = push_q;
  assign bus.arb_state = state_q;
  assign bus.idle      = (state_q == ST_IDLE) && (push_q == '0);

endmodule

// File: tb/tb_arbiter_rr.sv
// Directed testbench for arbiter_rr: each task drives one scenario and checks
// pop/push/state/idle against hand-computed values.
module tb_arbiter_rr;

  logic clk;
  logic reset_L;
  int   n_vec;
  int   n_err;

  arbiter_rr_if #(.FIFO_UNITS(4), .DEST_W(2)) bus ();

  arbiter_rr #(.FIFO_UNITS(4), .DEST_W(2)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_inputs(input logic [3:0] empty, input logic [3:0] af);
    bus.fifo_empty       = empty;
    bus.fifo_almost_full = af;
  endtask

  task automatic set_dests(input logic [1:0] d0, input logic [1:0] d1,
                           input logic [1:0] d2, input logic [1:0] d3);
    bus.head_dest0 = d0;
    bus.head_dest1 = d1;
    bus.head_dest2 = d2;
    bus.head_dest3 = d3;
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    set_inputs(4'b1111, 4'b0000);
    set_dests(2'b00, 2'b00, 2'b00, 2'b00);
    repeat (2) step();
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    set_inputs(4'b0000, 4'b0000);
    set_dests(2'b00, 2'b00, 2'b00, 2'b00);
    #2;
    n_vec++; if (bus.arb_pop !== 4'b0000) begin n_err++; $display("FAIL reset_pop got %b want 0000", bus.arb_pop); end
    n_vec++; if (bus.arb_push !== 4'b0000) begin n_err++; $display("FAIL reset_push got %b want 0000", bus.arb_push); end
    n_vec++; if (bus.arb_state !== 2'b00) begin n_err++; $display("FAIL reset_state got %b want 00", bus.arb_state); end
    n_vec++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got %b want 1", bus.idle); end
    // Pending inputs during reset must not produce a grant.
    repeat (2) step();
    n_vec++; if (bus.arb_pop !== 4'b0000) begin n_err++; $display("FAIL reset_hold_pop got %b want 0000", bus.arb_pop); end
    reset_L = 1'b1;
    n_vec++; if (bus.arb_pop !== 4'b0000) begin n_err++; $display("FAIL release_pop got %b want 0000", bus.arb_pop); end
    step();
    n_vec++; if (bus.arb_pop !== 4'b0001) begin n_err++; $display("FAIL first_grant_pop got %b want 0001", bus.arb_pop); end
  endtask

  task automatic test_single_word();
    do_reset();
    set_inputs(4'b1101, 4'b0000);
    set_dests(2'b00, 2'b10, 2'b00, 2'b00);
    step();
    n_vec++; if (bus.arb_pop !== 4'b0010) begin n_err++; $display("FAIL single_pop got %b want 0010", bus.arb_pop); end
    n_vec++; if (bus.arb_state !== 2'b01) begin n_err++; $display("FAIL single_state got %b want 01", bus.arb_state); end
    // Changing the head destination now must not alter the in-flight push.
    set_inputs(4'b1111, 4'b0000);
    set_dests(2'b00, 2'b01, 2'b00, 2'b00);
    step();
    n_vec++; if (bus.arb_pop !== 4'b0000) begin n_err++; $display("FAIL single_pop_done got %b want 0000", bus.arb_pop); end
    n_vec++; if (bus.arb_push !== 4'b0100) begin n_err++; $display("FAIL single_push got %b want 0100", bus.arb_push); end
    n_vec++; if (bus.arb_state !== 2'b00) begin n_err++; $display("FAIL single_back_idle got %b want 00", bus.arb_state); end
    n_vec++; if (bus.idle !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got %b want 0", bus.idle); end
    step();
    n_vec++; if (bus.arb_push !== 4'b0000) begin n_err++; $display("FAIL single_push_done got %b want 0000", bus.arb_push); end
    n_vec++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL single_idle got %b want 1", bus.idle); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_pop [5];
    exp_pop[0] = 4'b0001; exp_pop[1] = 4'b0010; exp_pop[2] = 4'b0100;
    exp_pop[3] = 4'b1000; exp_pop[4] = 4'b0001;
    do_reset();
    set_inputs(4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++; if (bus.arb_pop !== exp_pop[i]) begin n_err++; $display("FAIL fair_pop[%0d] got %b want %b", i, bus.arb_pop, exp_pop[i]); end
      if (i > 0) begin
        n_vec++; if (bus.arb_push !== 4'b0001) begin n_err++; $display("FAIL fair_push[%0d] got %b want 0001", i, bus.arb_push); end
      end
    end
    set_inputs(4'b1111, 4'b0000);
    repeat (3) step();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_inputs(4'b1010, 4'b1000);
    set_dests(2'b11, 2'b00, 2'b11, 2'b00);
    step();
    n_vec++; if (bus.arb_state !== 2'b01) begin n_err++; $display("FAIL bp_serve got %b want 01", bus.arb_state); end
    n_vec++; if (bus.arb_pop !== 4'b0000) begin n_err++; $display("FAIL bp_pop0 got %b want 0000", bus.arb_pop); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++; if (bus.arb_state !== 2'b10) begin n_err++; $display("FAIL bp_stall[%0d] got %b want 10", i, bus.arb_state); end
      n_vec++; if (bus.arb_pop !== 4'b0000) begin n_err++; $display("FAIL bp_stall_pop[%0d] got %b want 0000", i, bus.arb_pop); end
    end
    set_inputs(4'b1010, 4'b0000);
    step();
    n_vec++; if (bus.arb_state !== 2'b01) begin n_err++; $display("FAIL bp_resume got %b want 01", bus.arb_state); end
    n_vec++; if (bus.arb_pop !== 4'b0001) begin n_err++; $display("FAIL bp_pop_a got %b want 0001", bus.arb_pop); end
    step();
    n_vec++; if (bus.arb_pop !== 4'b0100) begin n_err++; $display("FAIL bp_pop_b got %b want 0100", bus.arb_pop); end
    n_vec++; if (bus.arb_push !== 4'b1000) begin n_err++; $display("FAIL bp_push_a got %b want 1000", bus.arb_push); end
    set_inputs(4'b1111, 4'b0000);
    step();
    n_vec++; if (bus.arb_pop !== 4'b0000) begin n_err++; $display("FAIL bp_pop_end got %b want 0000", bus.arb_pop); end
    n_vec++; if (bus.arb_push !== 4'b1000) begin n_err++; $display("FAIL bp_push_b got %b want 1000", bus.arb_push); end
  endtask

  task automatic test_af_inflight();
    do_reset();
    set_inputs(4'b1110, 4'b0000);
    set_dests(2'b11, 2'b00, 2'b11, 2'b00);
    step();
    n_vec++; if (bus.arb_pop !== 4'b0001) begin n_err++; $display("FAIL afi_pop got %b want 0001", bus.arb_pop); end
    // Destination 3 fills up while the word is in flight; input 2 also targets 3.
    set_inputs(4'b1010, 4'b1000);
    step();
    n_vec++; if (bus.arb_push !== 4'b1000) begin n_err++; $display("FAIL afi_push got %b want 1000", bus.arb_push); end
    n_vec++; if (bus.arb_pop !== 4'b0000) begin n_err++; $display("FAIL afi_no_grant got %b want 0000", bus.arb_pop); end
    n_vec++; if (bus.arb_state !== 2'b10) begin n_err++; $display("FAIL afi_stall got %b want 10", bus.arb_state); end
  endtask

  task automatic test_wrap();
    do_reset();
    set_inputs(4'b1011, 4'b0000);
    set_dests(2'b00, 2'b00, 2'b00, 2'b00);
    step();
    n_vec++; if (bus.arb_pop !== 4'b0100) begin n_err++; $display("FAIL wrap_setup got %b want 0100", bus.arb_pop); end
    // ptr is now 3; only input 0 pending.
    set_inputs(4'b1110, 4'b0000);
    step();
    n_vec++; if (bus.arb_pop !== 4'b0001) begin n_err++; $display("FAIL wrap_pop got %b want 0001", bus.arb_pop); end
    // ptr is now 1; input 0 is masked by its own pop, so input 1 must win over 2 and 3.
    set_inputs(4'b0000, 4'b0000);
    step();
    n_vec++; if (bus.arb_pop !== 4'b0010) begin n_err++; $display("FAIL wrap_ptr got %b want 0010", bus.arb_pop); end
    set_inputs(4'b1111, 4'b0000);
    repeat (3) step();
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_inputs(4'b1011, 4'b0000);
    set_dests(2'b00, 2'b00, 2'b01, 2'b00);
    step();
    n_vec++; if (bus.arb_pop !== 4'b0100) begin n_err++; $display("FAIL mr_pop got %b want 0100", bus.arb_pop); end
    set_inputs(4'b1111, 4'b0000);
    #2;
    reset_L = 1'b0;
    #1;
    n_vec++; if (bus.arb_pop !== 4'b0000) begin n_err++; $display("FAIL mr_async_pop got %b want 0000", bus.arb_pop); end
    n_vec++; if (bus.arb_push !== 4'b0000) begin n_err++; $display("FAIL mr_async_push got %b want 0000", bus.arb_push); end
    n_vec++; if (bus.arb_state !== 2'b00) begin n_err++; $display("FAIL mr_async_state got %b want 00", bus.arb_state); end
    n_vec++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL mr_async_idle got %b want 1", bus.idle); end
    repeat (2) step();
    reset_L = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (bus.arb_push !== 4'b0000) begin n_err++; $display("FAIL mr_no_push[%0d] got %b want 0000", i, bus.arb_push); end
      n_vec++; if (bus.arb_state !== 2'b00) begin n_err++; $display("FAIL mr_state[%0d] got %b want 00", i, bus.arb_state); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_L = 1'b0;
    set_inputs(4'b1111, 4'b0000);
    set_dests(2'b00, 2'b00, 2'b00, 2'b00);
    test_reset();
    test_single_word();
    test_fairness();
    test_backpressure();
    test_af_inflight();
    test_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arbiter_rr.md
ARBITER_RR -- requirements
Module: arbiter_rr

Interface
REQ-001 Parameter FIFO_UNITS, default 4, number of input FIFOs and output FIFOs; only 4 is supported.
REQ-002 Parameter DEST_W, default 2, destination field width; equals word bits [9:8] of the 10-bit word.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 fifo_empty  input  4  bit i high = input FIFO i empty.
REQ-006 head_dest0..head_dest3  input  2 each  bits [9:8] of the head word of input FIFO i; valid when fifo_empty[i] is low.
REQ-007 fifo_almost_full  input  4  bit j high = output FIFO j cannot accept another in-flight word.
REQ-008 arb_pop  output  4  one-hot or zero pop strobe to the input FIFOs; registered.
REQ-009 arb_push  output  4  one-hot or zero push strobe to the output FIFOs; registered.
REQ-010 arb_state  output  2  current FSM state encoding.
REQ-011 idle  output  1  high when no input word is pending and no push is in flight.

Function
REQ-012 FSM states: IDLE=2'b00, SERVE=2'b01, STALL=2'b10; 2'b11 unused, recovers to IDLE next cycle.
REQ-013 Candidate i eligible when fifo_empty[i]=0 and fifo_almost_full[head_dest_i]=0.
REQ-014 At most one candidate granted per cycle; grant is round-robin starting from priority pointer ptr (2 bits), searching ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-015 On grant to i: arb_pop = one-hot(i) in the next cycle, ptr <= i+1 mod 4 (3 wraps to 0).
REQ-016 No grant: arb_pop = 4'b0000 next cycle; ptr unchanged.
REQ-017 arb_push asserted exactly one cycle after the corresponding arb_pop, one-hot(destination captured at grant); latency grant-decision to push = 2 cycles.
REQ-018 Destination captured at grant time; later changes of head_dest do not affect the in-flight push.
REQ-019 Back-to-back grants allowed; pop and push may be high in the same cycle for different words.
REQ-020 Transitions: IDLE->SERVE when any fifo_empty bit is 0; SERVE->STALL when no empty bit is 0 eligible but some input non-empty; STALL->SERVE when any candidate eligible; SERVE/STALL->IDLE when fifo_empty=4'b1111.
REQ-021 Grants issued only in SERVE, evaluated in the same cycle the transition into SERVE is decided.
REQ-022 A candidate whose FIFO is being popped this cycle (arb_pop[i]=1) is not regranted in the same cycle; single-word FIFO empty flag lags one cycle.
REQ-023 Almost-full rising while a push to that destination is in flight: the in-flight push completes; no new grant to that destination.
REQ-024 idle = (state==IDLE) and arb_push==0.

Reset
REQ-025 reset_L low asynchronously forces: state=IDLE, ptr=0, arb_pop=0, arb_push=0, captured destination=0, idle=1.
REQ-026 Reset asserted mid-transfer drops any in-flight push; no push issued after release for words popped before reset.
REQ-027 First grant no earlier than first rising edge after reset_L goes high.

Verification
REQ-028 Reset: reset_L=0 with arb_pop active -> arb_pop, arb_push = 4'b0000 immediately, arb_state=00, idle=1.
REQ-029 Single word: fifo_empty=4'b1101, head_dest1=2'b10, almost_full=0 -> arb_pop=4'b0010 cycle N, arb_push=4'b0100 cycle N+1, then IDLE.
REQ-030 Fairness: all four non-empty, all dest 2'b00, almost_full=0 -> pops 0001,0010,0100,1000,0001 in consecutive cycles.
REQ-031 Backpressure: input 0 and 2 non-empty, dest 2'b11, almost_full=4'b1000 -> STALL, no pop; clear almost_full -> SERVE, pop 0001 then 0100.
REQ-032 Wrap: ptr=3, only input 0 non-empty -> pop 4'b0001, ptr becomes 1.
REQ-033 Mid-reset: reset_L low in cycle after pop 0100 -> no arb_push, state IDLE after release.
